// File: rtl/mdio_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mdio_master                                                  |
// | Description : Command-driven IEEE 802.3 MDIO management master. Each       |
// |               accepted command produces one management frame (optional     |
// |               preamble, 32-bit frame, released idle tail) and one          |
// |               response pulse. MDC is derived from clk by a fixed divider.  |
// | Optional    : define MDIO_CL45_EN to enable clause-45 framing (ST=00,      |
// |               raw OP) when cmd_cl45=1; otherwise cmd_cl45 is ignored.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Parameters
//   DIV           MDC half-period in clk cycles (2..255); MDC period = 2*DIV
//   PREAMBLE_LEN  preamble '1' bits before ST (0..63), 0 suppresses preamble
//   IDLE_BITS     released MDC periods after each frame (1..7)
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (ready only while idle)
//   cmd_op, cmd_cl45         OP field (cmd_op[1]=1 -> read), clause-45 select
//   cmd_phy, cmd_reg         PHYAD/PRTAD, REGAD/DEVAD
//   cmd_wdata                write data / clause-45 address
//   rsp_valid                one-cycle pulse at the end of every frame
//   rsp_rdata, rsp_err       read data and missing-PHY flag (read frames only)
//   busy                     high from command accept until rsp_valid
//   mdc, mdio_o, mdio_oe     management clock and split tristate MDIO output
//   mdio_i                   MDIO pad input (asynchronous)
module mdio_master #(
   parameter int DIV          = 32,
   parameter int PREAMBLE_LEN = 32,
   parameter int IDLE_BITS    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic        cmd_cl45,
   input  logic [4:0]  cmd_phy,
   input  logic [4:0]  cmd_reg,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        mdc,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        mdio_i
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRE   = 2'd1,
      ST_FRAME = 2'd2,
      ST_TAIL  = 2'd3
   } state_t;

   localparam logic [7:0] c_div_last  = 8'(DIV - 1);
   localparam logic [5:0] c_pre_last  = 6'(PREAMBLE_LEN - 1);
   localparam logic [5:0] c_tail_last = 6'(IDLE_BITS - 1);

   state_t       state_q, state_d;
   logic [7:0]   div_q, div_d;
   logic         phase_q, phase_d;
   logic [5:0]   cnt_q, cnt_d;
   logic [31:0]  shreg_q, shreg_d;
   logic         rd_op_q, rd_op_d;
   logic [15:0]  rd_q, rd_d;
   logic         err_q, err_d;
   logic         cmd_ready_q, cmd_ready_d;
   logic         busy_q, busy_d;
   logic         rsp_valid_q, rsp_valid_d;
   logic [15:0]  rsp_rdata_q, rsp_rdata_d;
   logic         rsp_err_q, rsp_err_d;
   logic         mdio_o_q, mdio_o_d;
   logic         mdio_oe_q, mdio_oe_d;
   logic         sync1_q, sync2_q;

   logic [1:0]   w_st;
   logic [1:0]   w_ta;
   logic [31:0]  w_frame;
   logic         w_div_wrap;
   logic         w_bit_end;

`ifdef MDIO_CL45_EN
   assign w_st = cmd_cl45 ? 2'b00 : 2'b01;
`else
   logic w_unused_cl45;
   assign w_unused_cl45 = cmd_cl45;
   assign w_st          = 2'b01;
`endif

   // TA bits of a read frame are never driven; the value only fills the slot.
   assign w_ta    = cmd_op[1] ? 2'b11 : 2'b10;
   assign w_frame = {w_st, cmd_op, cmd_phy, cmd_reg, w_ta, cmd_wdata};

   assign w_div_wrap = (div_q == c_div_last);
   // Last clk cycle of the MDC high phase: sample point and end of the bit.
   assign w_bit_end  = phase_q && w_div_wrap;

   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      phase_d     = phase_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      rd_op_d     = rd_op_q;
      rd_d        = rd_q;
      err_d       = err_q;
      cmd_ready_d = cmd_ready_q;
      busy_d      = busy_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      mdio_o_d    = mdio_o_q;
      mdio_oe_d   = mdio_oe_q;

      // MDC divider only runs while a frame is in progress.
      if (state_q != ST_IDLE) begin
         div_d = w_div_wrap ? 8'd0 : div_q + 8'd1;
         if (w_div_wrap) begin
            phase_d = ~phase_q;
         end
      end

      case (state_q)
         ST_IDLE: begin
            div_d     = 8'd0;
            phase_d   = 1'b0;
            mdio_oe_d = 1'b0;
            mdio_o_d  = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               shreg_d     = w_frame;
               rd_op_d     = cmd_op[1];
               rd_d        = 16'd0;
               err_d       = 1'b0;
               cnt_d       = 6'd0;
               cmd_ready_d = 1'b0;
               busy_d      = 1'b1;
               mdio_oe_d   = 1'b1;
               if (PREAMBLE_LEN == 0) begin
                  state_d  = ST_FRAME;
                  mdio_o_d = w_frame[31];
               end else begin
                  state_d  = ST_PRE;
                  mdio_o_d = 1'b1;
               end
            end
         end

         ST_PRE: begin
            if (w_bit_end) begin
               if (cnt_q == c_pre_last) begin
                  state_d  = ST_FRAME;
                  cnt_d    = 6'd0;
                  mdio_o_d = shreg_q[31];
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end

         ST_FRAME: begin
            if (w_bit_end) begin
               // Bit 15 is the second TA bit: a present PHY pulls it low.
               if (rd_op_q && (cnt_q == 6'd15)) begin
                  err_d = sync2_q;
               end
               if (rd_op_q && (cnt_q >= 6'd16)) begin
                  rd_d = {rd_q[14:0], sync2_q};
               end
               shreg_d = {shreg_q[30:0], 1'b1};
               if (cnt_q == 6'd31) begin
                  state_d   = ST_TAIL;
                  cnt_d     = 6'd0;
                  mdio_oe_d = 1'b0;
                  mdio_o_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 6'd1;
                  // Reads release the line from the first TA bit onwards.
                  if (rd_op_q && (cnt_q >= 6'd13)) begin
                     mdio_oe_d = 1'b0;
                     mdio_o_d  = 1'b1;
                  end else begin
                     mdio_oe_d = 1'b1;
                     mdio_o_d  = shreg_q[30];
                  end
               end
            end
         end

         ST_TAIL: begin
            if (w_bit_end) begin
               if (cnt_q == c_tail_last) begin
                  state_d     = ST_IDLE;
                  cnt_d       = 6'd0;
                  rsp_valid_d = 1'b1;
                  cmd_ready_d = 1'b1;
                  busy_d      = 1'b0;
                  rsp_err_d   = rd_op_q && err_q;
                  if (rd_op_q) begin
                     rsp_rdata_d = rd_q;
                  end
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         div_q       <= 8'd0;
         phase_q     <= 1'b0;
         cnt_q       <= 6'd0;
         shreg_q     <= 32'd0;
         rd_op_q     <= 1'b0;
         rd_q        <= 16'd0;
         err_q       <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 16'd0;
         rsp_err_q   <= 1'b0;
         mdio_o_q    <= 1'b1;
         mdio_oe_q   <= 1'b0;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         rd_op_q     <= rd_op_d;
         rd_q        <= rd_d;
         err_q       <= err_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         mdio_o_q    <= mdio_o_d;
         mdio_oe_q   <= mdio_oe_d;
         sync1_q     <= mdio_i;
         sync2_q     <= sync1_q;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign mdc       = phase_q;
   assign mdio_o    = mdio_o_q;
   assign mdio_oe   = mdio_oe_q;

endmodule
`default_nettype wire

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Parametrised, command-driven IEEE 802.3 MDIO management master for board PHYs.
- Replaces fixed-sequence register sweepers with a valid/ready command port: any PHY address, any register, read or write, one frame per command.
- Generates MDC from `clk` by a programmable divider and presents split tristate signals (`mdio_o`/`mdio_oe`/`mdio_i`) for the top-level IOBUF.
- Sits between board-support control logic (local bus / config sequencer) and the PHY management pins.

Parameters:
- DIV, 32, MDC half-period in `clk` cycles; legal range 2..255. MDC period is 2*DIV.
- PREAMBLE_LEN, 32, number of preamble '1' bits before ST; legal range 0..63. 0 means preamble suppressed.
- IDLE_BITS, 1, number of released MDC periods after each frame; legal range 1..7.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when the block accepts a command (IDLE state)
- cmd_op  in  2  raw OP field; cmd_op[1]=1 selects a read frame
- cmd_cl45  in  1  clause-45 frame select (see Optional Feature)
- cmd_phy  in  5  PHYAD / PRTAD
- cmd_reg  in  5  REGAD / DEVAD
- cmd_wdata  in  16  write data / C45 address
- rsp_valid  out  1  one-cycle pulse at end of every frame
- rsp_rdata  out  16  read data; holds until next rsp_valid
- rsp_err  out  1  read frame with TA bit1 sampled as 1 (no PHY); qualified by rsp_valid
- busy  out  1  high from command accept until rsp_valid
- mdc  out  1  management clock
- mdio_o  out  1  MDIO output value
- mdio_oe  out  1  MDIO output enable, 1 = drive
- mdio_i  in  1  MDIO pad input (asynchronous)

Behaviour:
- Reset values: `cmd_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mdc`=0, `mdio_o`=1, `mdio_oe`=0. State = IDLE, divider = 0.
- Reset mid-frame: abort immediately, return to the reset values next cycle, no `rsp_valid`.
- `mdio_i` passes through a 2-flop synchroniser before use.
- Accept: `cmd_valid & cmd_ready` in IDLE. All command fields are latched into a 32-bit shift register and control flags. `cmd_ready` drops the next cycle.
- MDC timing:
  - Divider counts 0..DIV-1. Each wrap toggles a phase bit; `mdc` equals the phase bit, registered.
  - `mdc` low phase first.
  - New bit and `mdio_oe` update on the cycle `mdc` goes low.
  - Input sampling uses the synchronised `mdio_i` on the last cycle of the high phase, immediately before the falling edge.
- States:
  - IDLE: `mdc` stays 0 and `mdio_oe`=0.
  - PRE: PREAMBLE_LEN bits of '1', driven. Skipped if PREAMBLE_LEN=0.
  - FRAME: 32 bits, MSB first: ST(2) OP(2) PHY(5) REG(5) TA(2) DATA(16).
    - Write frame: all 32 bits driven, TA=10.
    - Read frame: first 14 bits driven, then `mdio_oe`=0 for TA and DATA. TA bit1 is sampled into an error flag; the 16 DATA bits are shifted into `rsp_rdata` (MSB first).
  - TAIL: IDLE_BITS MDC periods with `mdio_oe`=0. On the final cycle, `rsp_valid`=1, return to IDLE, `cmd_ready`=1 the following cycle.
- Latency, write, PREAMBLE_LEN=32, IDLE_BITS=1: accept to `rsp_valid` = (32+32+1)*2*DIV cycles ±2.
- `rsp_rdata` updates only on read frames. `rsp_err` is 0 for writes.
- `cmd_valid` while busy is ignored (no queueing). The requester must hold `cmd_valid` until `cmd_ready`.
- A bit counter of 6 bits wraps only via state change. No combinational path from `cmd_valid` to `cmd_ready`.

Optional Feature:
- Macro: `MDIO_CL45_EN`.
- Defined, with `cmd_cl45`=1: ST=00 and OP=`cmd_op` raw. 00 = address, 01 = write, 11 = read, 10 = post-read-increment read. `cmd_phy` → PRTAD, `cmd_reg` → DEVAD, `cmd_wdata` carries address/write data. Read framing applies when `cmd_op[1]`=1.
- Defined, with `cmd_cl45`=0, or macro absent: `cmd_cl45` is ignored and ST=01 (clause 22). Clause-22 reads use `cmd_op`=10, writes use `cmd_op`=01.

Test Plan:
- Reset, then idle 500 cycles → `mdc`=0, `mdio_oe`=0, `cmd_ready`=1, no `rsp_valid`.
- C22 write, phy=7, reg=22, wdata=0x0001, DIV=4 → MDC period 8 clk. Captured bitstream = 32 ones then 0101_00111_10110_10_0000000000000001, `mdio_oe` high throughout. `rsp_valid` once, `rsp_err`=0.
- C22 read, phy=7, reg=0; bench PHY model drives TA=z0 and data 0x1140 after each rising edge → `mdio_oe` falls after bit 14, `rsp_rdata`=0x1140, `rsp_err`=0.
- Read with no PHY (pull-up, all ones) → `rsp_err`=1, `rsp_rdata`=0xFFFF.
- PREAMBLE_LEN=0, back-to-back `cmd_valid` held high → second frame starts exactly IDLE_BITS MDC periods after the first. Second `cmd_valid` is ignored until `cmd_ready`.
- Assert `rst` at FRAME bit 10 → next cycle `mdio_oe`=0, `mdc`=0, no `rsp_valid`. A following command completes normally; with `MDIO_CL45_EN`, a C45 address op (`cmd_op`=00) produces ST=00.
